// File: rtl/stream_pkg.sv
// Shared types and helpers for the stream arbiter slice.
package stream_pkg;

    localparam int unsigned DEFAULT_DATA_WIDTH = 8;

    typedef enum logic [0:0] {
        IDLE   = 1'b0,
        LOCKED = 1'b1
    } arb_state_t;

    function automatic int unsigned clog2(input int unsigned value);
        int unsigned result;
        result = 0;
        for (longint unsigned w = 1; w < longint'(value); w = w << 1) begin
            result++;
        end
        return result;
    endfunction

endpackage

// File: rtl/stream_pipe_reg.sv
// One-entry valid/ready output register; payload holds while stalled.
module stream_pipe_reg #(
    parameter int unsigned WIDTH = 1
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] in_data,
    output logic             out_valid,
    output logic [WIDTH-1:0] out_data,
    input  logic             out_ready
);

    logic             valid_q;
    logic [WIDTH-1:0] data_q;

    // Accept whenever the slot is empty or being drained this cycle.
    assign in_ready = ~valid_q | out_ready;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            valid_q <= 1'b0;
            data_q  <= '0;
        end else if (in_valid && in_ready) begin
            valid_q <= 1'b1;
            data_q  <= in_data;
        end else if (out_ready) begin
            valid_q <= 1'b0;
        end
    end

    assign out_valid = valid_q;
    assign out_data  = data_q;

endmodule

// File: rtl/stream_packet_arbiter.sv
// Packet-atomic round-robin arbiter sharing one registered stream source.
module stream_packet_arbiter
    import stream_pkg::*;
#(
    parameter  int unsigned N_SINKS    = 4,
    parameter  int unsigned DATA_WIDTH = DEFAULT_DATA_WIDTH,
    localparam int unsigned ID_WIDTH   = (N_SINKS > 1) ? clog2(N_SINKS) : 1
) (
    input  logic                          sys_clk,
    input  logic                          sys_rst_n,
    input  logic [N_SINKS-1:0]            sink_valid,
    input  logic [N_SINKS-1:0]            sink_last,
    input  logic [N_SINKS*DATA_WIDTH-1:0] sink_data,
    output logic [N_SINKS-1:0]            sink_ready,
    output logic                          source_valid,
    output logic                          source_last,
    output logic [DATA_WIDTH-1:0]         source_data,
    output logic [ID_WIDTH-1:0]           source_id,
    input  logic                          source_ready,
    output logic                          busy
);

    localparam int unsigned PAYLOAD_WIDTH = DATA_WIDTH + ID_WIDTH + 1;

    arb_state_t state_q, state_d;

    logic [ID_WIDTH-1:0]      grant_q, grant_d;
    logic [ID_WIDTH-1:0]      rr_ptr_q, rr_ptr_d;
    logic [ID_WIDTH-1:0]      rr_pick;
    logic                     rr_found;
    int unsigned              rr_idx;

    logic                     pipe_in_ready;
    logic                     beat_valid;
    logic                     beat_last;
    logic [DATA_WIDTH-1:0]    beat_data;
    logic [PAYLOAD_WIDTH-1:0] pipe_in_payload;
    logic [PAYLOAD_WIDTH-1:0] pipe_out_payload;

    // First requester scanning from one past the previous packet's owner.
    always_comb begin
        rr_pick  = rr_ptr_q;
        rr_found = 1'b0;
        rr_idx   = 0;
        for (int unsigned i = 1; i <= N_SINKS; i++) begin
            rr_idx = (32'(rr_ptr_q) + i) % N_SINKS;
            if (!rr_found && sink_valid[rr_idx]) begin
                rr_found = 1'b1;
                rr_pick  = ID_WIDTH'(rr_idx);
            end
        end
    end

    assign beat_last = sink_last[grant_q];
    assign beat_data = sink_data[grant_q*DATA_WIDTH +: DATA_WIDTH];

    always_comb begin
        state_d    = state_q;
        grant_d    = grant_q;
        rr_ptr_d   = rr_ptr_q;
        sink_ready = '0;
        beat_valid = 1'b0;
        unique case (state_q)
            IDLE: begin
                if (rr_found) begin
                    grant_d = rr_pick;
                    state_d = LOCKED;
                end
            end
            LOCKED: begin
                sink_ready[grant_q] = pipe_in_ready;
                beat_valid          = sink_valid[grant_q];
                if (beat_valid && pipe_in_ready && beat_last) begin
                    rr_ptr_d = grant_q;
                    state_d  = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge sys_clk or negedge sys_rst_n) begin
        if (!sys_rst_n) begin
            state_q  <= IDLE;
            grant_q  <= '0;
            rr_ptr_q <= ID_WIDTH'(N_SINKS - 1);
        end else begin
            state_q  <= state_d;
            grant_q  <= grant_d;
            rr_ptr_q <= rr_ptr_d;
        end
    end

    assign pipe_in_payload = {beat_last, grant_q, beat_data};

    stream_pipe_reg #(
        .WIDTH(PAYLOAD_WIDTH)
    ) u_out_reg (
        .clk      (sys_clk),
        .rst_n    (sys_rst_n),
        .in_valid (beat_valid),
        .in_ready (pipe_in_ready),
        .in_data  (pipe_in_payload),
        .out_valid(source_valid),
        .out_data (pipe_out_payload),
        .out_ready(source_ready)
    );

    assign {source_last, source_id, source_data} = pipe_out_payload;
    assign busy = (state_q == LOCKED);

endmodule

// File: tb/tb_stream_packet_arbiter.sv
// Directed, table-driven bench for stream_packet_arbiter (4 sinks, 8-bit data).
module tb_stream_packet_arbiter;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic [3:0]  sink_valid = '0;
    logic [3:0]  sink_last = '0;
    logic [31:0] sink_data = '0;
    logic [3:0]  sink_ready;
    logic        source_valid;
    logic        source_last;
    logic [7:0]  source_data;
    logic [1:0]  source_id;
    logic        source_ready = 1'b0;
    logic        busy;

    int checks = 0;
    int errors = 0;

    always #5 clk = ~clk;

    stream_packet_arbiter #(
        .N_SINKS   (4),
        .DATA_WIDTH(8)
    ) dut (
        .sys_clk     (clk),
        .sys_rst_n   (rst_n),
        .sink_valid  (sink_valid),
        .sink_last   (sink_last),
        .sink_data   (sink_data),
        .sink_ready  (sink_ready),
        .source_valid(source_valid),
        .source_last (source_last),
        .source_data (source_data),
        .source_id   (source_id),
        .source_ready(source_ready),
        .busy        (busy)
    );

    typedef struct {
        logic        rst;
        logic [3:0]  sv;
        logic [3:0]  sl;
        logic [31:0] sd;
        logic        sr;
        logic        ov;
        logic        ol;
        logic [7:0]  od;
        logic [1:0]  oid;
        logic [3:0]  ordy;
        logic        obusy;
    } vec_t;

    vec_t vecs[$];

    function automatic void add(input logic rst, input logic [3:0] sv, input logic [3:0] sl,
                                input logic [7:0] d0, input logic [7:0] d1,
                                input logic [7:0] d2, input logic [7:0] d3, input logic sr,
                                input logic ov, input logic ol, input logic [7:0] od,
                                input logic [1:0] oid, input logic [3:0] ordy,
                                input logic obusy);
        vec_t v;
        v.rst = rst; v.sv = sv; v.sl = sl; v.sd = {d3, d2, d1, d0}; v.sr = sr;
        v.ov = ov; v.ol = ol; v.od = od; v.oid = oid; v.ordy = ordy; v.obusy = obusy;
        vecs.push_back(v);
    endfunction

    task automatic check_vec(input int k, input vec_t v);
        logic ok;
        ok = (source_valid === v.ov) && (sink_ready === v.ordy) && (busy === v.obusy);
        // Payload is only meaningful while valid, or in reset where it must read zero.
        if (v.ov || !v.rst)
            ok = ok && (source_last === v.ol) && (source_data === v.od) && (source_id === v.oid);
        checks++;
        if (!ok) begin
            errors++;
            $display("FAIL vec%0d: v/l/d/id/rdy/busy got %b/%b/%h/%0d/%b/%b want %b/%b/%h/%0d/%b/%b",
                     k, source_valid, source_last, source_data, source_id, sink_ready, busy,
                     v.ov, v.ol, v.od, v.oid, v.ordy, v.obusy);
        end
    endtask

    task automatic check_eq(input string name, input int got, input int want);
        checks++;
        if (got != want) begin
            errors++;
            $display("FAIL %s: got %0d want %0d", name, got, want);
        end
    endtask

    int lat;

    initial begin
        // Reset
        add(0, 4'b0000, 4'b0000, 8'h00, 8'h00, 8'h00, 8'h00, 1, 0, 0, 8'h00, 0, 4'b0000, 0);
        // Sinks 0 and 2, three beats each
        add(1, 4'b0101, 4'b0000, 8'h10, 8'h00, 8'h20, 8'h00, 1, 0, 0, 8'h00, 0, 4'b0000, 0);
        add(1, 4'b0101, 4'b0000, 8'h10, 8'h00, 8'h20, 8'h00, 1, 0, 0, 8'h00, 0, 4'b0001, 1);
        add(1, 4'b0101, 4'b0000, 8'h11, 8'h00, 8'h20, 8'h00, 1, 1, 0, 8'h10, 0, 4'b0001, 1);
        add(1, 4'b0101, 4'b0001, 8'h12, 8'h00, 8'h20, 8'h00, 1, 1, 0, 8'h11, 0, 4'b0001, 1);
        add(1, 4'b0100, 4'b0000, 8'h00, 8'h00, 8'h20, 8'h00, 1, 1, 1, 8'h12, 0, 4'b0000, 0);
        add(1, 4'b0100, 4'b0000, 8'h00, 8'h00, 8'h20, 8'h00, 1, 0, 0, 8'h00, 0, 4'b0100, 1);
        add(1, 4'b0100, 4'b0000, 8'h00, 8'h00, 8'h21, 8'h00, 1, 1, 0, 8'h20, 2, 4'b0100, 1);
        add(1, 4'b0100, 4'b0100, 8'h00, 8'h00, 8'h22, 8'h00, 1, 1, 0, 8'h21, 2, 4'b0100, 1);
        add(1, 4'b0000, 4'b0000, 8'h00, 8'h00, 8'h00, 8'h00, 1, 1, 1, 8'h22, 2, 4'b0000, 0);
        add(1, 4'b0000, 4'b0000, 8'h00, 8'h00, 8'h00, 8'h00, 1, 0, 0, 8'h00, 0, 4'b0000, 0);
        // Reset, then all four sinks with continuous single-beat packets
        add(0, 4'b0000, 4'b0000, 8'h00, 8'h00, 8'h00, 8'h00, 1, 0, 0, 8'h00, 0, 4'b0000, 0);
        add(1, 4'b1111, 4'b1111, 8'h30, 8'h31, 8'h32, 8'h33, 1, 0, 0, 8'h00, 0, 4'b0000, 0);
        add(1, 4'b1111, 4'b1111, 8'h30, 8'h31, 8'h32, 8'h33, 1, 0, 0, 8'h00, 0, 4'b0001, 1);
        add(1, 4'b1111, 4'b1111, 8'h30, 8'h31, 8'h32, 8'h33, 1, 1, 1, 8'h30, 0, 4'b0000, 0);
        add(1, 4'b1111, 4'b1111, 8'h30, 8'h31, 8'h32, 8'h33, 1, 0, 0, 8'h00, 0, 4'b0010, 1);
        add(1, 4'b1111, 4'b1111, 8'h30, 8'h31, 8'h32, 8'h33, 1, 1, 1, 8'h31, 1, 4'b0000, 0);
        add(1, 4'b1111, 4'b1111, 8'h30, 8'h31, 8'h32, 8'h33, 1, 0, 0, 8'h00, 0, 4'b0100, 1);
        add(1, 4'b1111, 4'b1111, 8'h30, 8'h31, 8'h32, 8'h33, 1, 1, 1, 8'h32, 2, 4'b0000, 0);
        add(1, 4'b1111, 4'b1111, 8'h30, 8'h31, 8'h32, 8'h33, 1, 0, 0, 8'h00, 0, 4'b1000, 1);
        add(1, 4'b1111, 4'b1111, 8'h30, 8'h31, 8'h32, 8'h33, 1, 1, 1, 8'h33, 3, 4'b0000, 0);
        add(1, 4'b1111, 4'b1111, 8'h30, 8'h31, 8'h32, 8'h33, 1, 0, 0, 8'h00, 0, 4'b0001, 1);
        add(1, 4'b0000, 4'b0000, 8'h30, 8'h31, 8'h32, 8'h33, 1, 1, 1, 8'h30, 0, 4'b0000, 0);
        add(1, 4'b0000, 4'b0000, 8'h00, 8'h00, 8'h00, 8'h00, 1, 0, 0, 8'h00, 0, 4'b0000, 0);
        // Sink 1 four-beat packet with a five-cycle downstream stall
        add(1, 4'b0010, 4'b0000, 8'h00, 8'h40, 8'h00, 8'h00, 1, 0, 0, 8'h00, 0, 4'b0000, 0);
        add(1, 4'b0010, 4'b0000, 8'h00, 8'h40, 8'h00, 8'h00, 1, 0, 0, 8'h00, 0, 4'b0010, 1);
        add(1, 4'b0010, 4'b0000, 8'h00, 8'h41, 8'h00, 8'h00, 1, 1, 0, 8'h40, 1, 4'b0010, 1);
        for (int i = 0; i < 5; i++)
            add(1, 4'b0010, 4'b0000, 8'h00, 8'h42, 8'h00, 8'h00, 0, 1, 0, 8'h41, 1, 4'b0000, 1);
        add(1, 4'b0010, 4'b0000, 8'h00, 8'h42, 8'h00, 8'h00, 1, 1, 0, 8'h41, 1, 4'b0010, 1);
        add(1, 4'b0010, 4'b0010, 8'h00, 8'h43, 8'h00, 8'h00, 1, 1, 0, 8'h42, 1, 4'b0010, 1);
        add(1, 4'b0000, 4'b0000, 8'h00, 8'h00, 8'h00, 8'h00, 1, 1, 1, 8'h43, 1, 4'b0000, 0);
        add(1, 4'b0000, 4'b0000, 8'h00, 8'h00, 8'h00, 8'h00, 1, 0, 0, 8'h00, 0, 4'b0000, 0);
        // Sink 2 granted, drops valid for three cycles while sink 1 waits
        add(1, 4'b0110, 4'b0010, 8'h00, 8'h60, 8'h50, 8'h00, 1, 0, 0, 8'h00, 0, 4'b0000, 0);
        add(1, 4'b0110, 4'b0010, 8'h00, 8'h60, 8'h50, 8'h00, 1, 0, 0, 8'h00, 0, 4'b0100, 1);
        add(1, 4'b0010, 4'b0010, 8'h00, 8'h60, 8'h51, 8'h00, 1, 1, 0, 8'h50, 2, 4'b0100, 1);
        add(1, 4'b0010, 4'b0010, 8'h00, 8'h60, 8'h51, 8'h00, 1, 0, 0, 8'h00, 0, 4'b0100, 1);
        add(1, 4'b0010, 4'b0010, 8'h00, 8'h60, 8'h51, 8'h00, 1, 0, 0, 8'h00, 0, 4'b0100, 1);
        add(1, 4'b0110, 4'b0010, 8'h00, 8'h60, 8'h51, 8'h00, 1, 0, 0, 8'h00, 0, 4'b0100, 1);
        add(1, 4'b0110, 4'b0110, 8'h00, 8'h60, 8'h52, 8'h00, 1, 1, 0, 8'h51, 2, 4'b0100, 1);
        add(1, 4'b0010, 4'b0010, 8'h00, 8'h60, 8'h00, 8'h00, 1, 1, 1, 8'h52, 2, 4'b0000, 0);
        add(1, 4'b0010, 4'b0010, 8'h00, 8'h60, 8'h00, 8'h00, 1, 0, 0, 8'h00, 0, 4'b0010, 1);
        add(1, 4'b0000, 4'b0000, 8'h00, 8'h00, 8'h00, 8'h00, 1, 1, 1, 8'h60, 1, 4'b0000, 0);
        add(1, 4'b0000, 4'b0000, 8'h00, 8'h00, 8'h00, 8'h00, 1, 0, 0, 8'h00, 0, 4'b0000, 0);
        // Reset after two of four beats, then sink 3 single-beat packet
        add(1, 4'b0001, 4'b0000, 8'h70, 8'h00, 8'h00, 8'h00, 1, 0, 0, 8'h00, 0, 4'b0000, 0);
        add(1, 4'b0001, 4'b0000, 8'h70, 8'h00, 8'h00, 8'h00, 1, 0, 0, 8'h00, 0, 4'b0001, 1);
        add(1, 4'b0001, 4'b0000, 8'h71, 8'h00, 8'h00, 8'h00, 1, 1, 0, 8'h70, 0, 4'b0001, 1);
        add(0, 4'b0001, 4'b0000, 8'h72, 8'h00, 8'h00, 8'h00, 1, 0, 0, 8'h00, 0, 4'b0000, 0);
        add(1, 4'b1000, 4'b1000, 8'h00, 8'h00, 8'h00, 8'h80, 1, 0, 0, 8'h00, 0, 4'b0000, 0);
        add(1, 4'b1000, 4'b1000, 8'h00, 8'h00, 8'h00, 8'h80, 1, 0, 0, 8'h00, 0, 4'b1000, 1);
        add(1, 4'b0000, 4'b0000, 8'h00, 8'h00, 8'h00, 8'h00, 1, 1, 1, 8'h80, 3, 4'b0000, 0);
        add(1, 4'b0000, 4'b0000, 8'h00, 8'h00, 8'h00, 8'h00, 1, 0, 0, 8'h00, 0, 4'b0000, 0);

        foreach (vecs[k]) begin
            @(posedge clk);
            #1;
            rst_n        = vecs[k].rst;
            sink_valid   = vecs[k].sv;
            sink_last    = vecs[k].sl;
            sink_data    = vecs[k].sd;
            source_ready = vecs[k].sr;
            #3;
            check_vec(k, vecs[k]);
        end

        // First-beat latency from an idle request: expect two edges.
        @(posedge clk);
        #1;
        sink_valid = 4'b0100;
        sink_last  = 4'b0100;
        sink_data  = 32'h0099_0000;
        lat = 0;
        while (!source_valid && lat < 10) begin
            @(posedge clk);
            #1;
            lat++;
        end
        sink_valid = 4'b0000;
        sink_last  = 4'b0000;
        check_eq("latency", lat, 2);
        check_eq("lat_id", int'(source_id), 2);
        check_eq("lat_data", int'(source_data), 8'h99);
        check_eq("lat_last", int'(source_last), 1);
        @(posedge clk);
        #1;
        check_eq("lat_drain", int'(source_valid), 0);
        check_eq("lat_busy", int'(busy), 0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
